rv32i_retire_tracer: RTL and testbench
======================================

Name: rv32i_retire_tracer

Overview:
- Synthesizable retirement monitor placed directly downstream of the core's writeback stage inside rv32i_soc.
- Captures every retired instruction (PC, destination register write, trap/return flags) into a FIFO and drains it over a valid/ready stream to a debug sink (UART bridge or bench).
- Detects the ecall/ebreak halt condition and evaluates the riscv-tests exit convention (x17 == 0x5d, x10 == 0) in hardware, so silicon and simulation share one pass/fail criterion.

Parameters:
- FIFO_DEPTH, 16, number of trace records buffered; power of two, minimum 2.
- EXIT_MAGIC, 32'h0000005d, x17 value that marks a valid exit.
- CNT_WIDTH, 32, width of the retire and overflow counters.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ret_valid  in  1  one instruction retires this cycle (writeback_ce && !stall_writeback)
- i_ret_pc  in  32  PC of the retiring instruction
- i_ret_wr_rd  in  1  retiring instruction writes rd
- i_ret_rd_addr  in  5  destination register index
- i_ret_rd_data  in  32  value written to rd
- i_ret_trap  in  1  retirement redirected to trap (csr_go_to_trap)
- i_ret_mret  in  1  retirement is a return from trap
- i_ecall  in  1  ALU flags ecall
- i_ebreak  in  1  ALU flags ebreak
- o_trace_valid  out  1  trace record available
- i_trace_ready  in  1  sink accepts record
- o_trace_pc  out  32  record PC
- o_trace_rd_addr  out  5  record rd (0 when no rd write, or when rd == x0)
- o_trace_rd_data  out  32  record rd value (0 when o_trace_rd_addr is 0)
- o_trace_flags  out  3  {mret, trap, wr_rd}
- o_retire_cnt  out  CNT_WIDTH  instructions retired since reset
- o_overflow_cnt  out  CNT_WIDTH  records dropped because the FIFO was full
- o_halt  out  1  halt reached and FIFO drained
- o_pass  out  1  valid exit with exit code 0
- o_fail  out  1  valid exit with nonzero exit code
- o_exit_code  out  32  x10 >> 1 at halt

Behaviour:
- Reset: all outputs 0, FIFO empty, state RUN, shadow x10/x17 = 0. Reset asserted mid-drain discards all records immediately.
- Record capture:
  - Each cycle with i_ret_valid in RUN, push one record.
  - Write to rd == x0 is recorded with wr_rd = 0 and zero data.
  - o_retire_cnt increments on every i_ret_valid in RUN, whether or not the push succeeds.
- FIFO:
  - First-word-fall-through; the head record is presented combinationally from storage with o_trace_valid = !empty.
  - Pop on o_trace_valid && i_trace_ready.
  - Push and pop in the same cycle are both honoured when full: no drop, count unchanged.
  - Push while full with no pop: record dropped, o_overflow_cnt += 1, saturating at all-ones.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are tracked with an extra pointer bit.
  - Output fields hold stable while o_trace_valid && !i_trace_ready.
- Shadow registers: on retirement with wr_rd to x10 or x17, update the shadow copy in the same cycle as the push.
- State machine:
  - RUN -> DRAIN when (i_ecall | i_ebreak) is sampled high. The retirement in that same cycle, if any, is still captured. No further captures after that cycle.
  - DRAIN -> DONE the first cycle the FIFO is empty, including the entry cycle if the FIFO is already empty.
  - DONE: o_halt = 1, registered. o_exit_code = shadow_x10 >> 1.
  - In DONE: o_pass = (x17 == EXIT_MAGIC && x10 == 0); o_fail = (x17 == EXIT_MAGIC && x10 != 0).
  - DONE is sticky until reset.
- Latency:
  - A record pushed at edge N is visible on the outputs after edge N (o_trace_valid high in cycle N+1).
  - o_halt rises one edge after the FIFO becomes empty in DRAIN.

Decomposition:
- Shared package (rv32i_header): trace flag bit positions (TRACE_WR_RD = 0, TRACE_TRAP = 1, TRACE_MRET = 2) and the tracer state encodings RUN/DRAIN/DONE.
- One sub-module, rv32i_trace_fifo: a generic FWFT FIFO with parameters WIDTH and DEPTH, exposing full/empty flags. The tracer holds the state machine, counters and shadows.

Test Plan:
- Reset mid-stream: push 5 records, assert i_rst_n low for 3 cycles -> o_trace_valid = 0, o_retire_cnt = 0, o_halt = 0; the next retirement appears as the only record.
- Ordered drain: retire 4 instructions at PC 0x0,0x4,0x8,0xc with i_trace_ready = 1 -> 4 records appear in order, each the cycle after its push, o_retire_cnt = 4.
- Backpressure overflow (FIFO_DEPTH = 16): i_trace_ready = 0, retire 20 -> o_overflow_cnt = 4, o_retire_cnt = 20. Raise ready -> exactly 16 records, PCs of the first 16 retirements.
- Full push+pop: FIFO full, ready = 1, retire each cycle for 10 cycles -> o_overflow_cnt unchanged, occupancy stays 16.
- Pass exit: write x17 = 0x5d and x10 = 0, then ecall with 3 records queued and ready = 1 -> o_halt rises after the 3rd pop; o_pass = 1, o_fail = 0, o_exit_code = 0.
- Fail exit and x0 write: write x0 = 0x55 (record shows rd_addr 0, data 0, wr_rd = 0); x17 = 0x5d, x10 = 0x7; ebreak -> o_fail = 1, o_exit_code = 3. With x17 = 0x1 instead -> o_halt = 1, o_pass = o_fail = 0.

Source files
------------

// File: rtl/rv32i_header.sv
// Shared definitions for the retirement tracer: flag bit positions, tracer
// states and the packed trace record layout.
package rv32i_header;

    localparam int TRACE_WR_RD   = 0;
    localparam int TRACE_TRAP    = 1;
    localparam int TRACE_MRET    = 2;
    localparam int TRACE_FLAGS_W = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } tracer_state_e;

    typedef struct packed {
        logic [31:0]              pc;
        logic [4:0]               rd_addr;
        logic [31:0]              rd_data;
        logic [TRACE_FLAGS_W-1:0] flags;
    } trace_rec_t;

endpackage

// File: rtl/rv32i_trace_fifo.sv
// Generic first-word-fall-through FIFO. A push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module rv32i_trace_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    // The extra pointer MSB distinguishes full from empty when indices match.
    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok_s = i_push && (!o_full || i_pop);
    assign pop_ok_s  = i_pop && !o_empty;
    assign o_data    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage write
    always_ff @(posedge i_clk) begin
        if (push_ok_s) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/rv32i_retire_tracer.sv
// Retirement monitor: buffers retired-instruction records, tracks x10/x17
// shadows and evaluates the riscv-tests exit convention after ecall/ebreak.
module rv32i_retire_tracer
    import rv32i_header::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] EXIT_MAGIC = 32'h0000005d,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ret_valid,
    input  logic [31:0]          i_ret_pc,
    input  logic                 i_ret_wr_rd,
    input  logic [4:0]           i_ret_rd_addr,
    input  logic [31:0]          i_ret_rd_data,
    input  logic                 i_ret_trap,
    input  logic                 i_ret_mret,
    input  logic                 i_ecall,
    input  logic                 i_ebreak,
    output logic                 o_trace_valid,
    input  logic                 i_trace_ready,
    output logic [31:0]          o_trace_pc,
    output logic [4:0]           o_trace_rd_addr,
    output logic [31:0]          o_trace_rd_data,
    output logic [2:0]           o_trace_flags,
    output logic [CNT_WIDTH-1:0] o_retire_cnt,
    output logic [CNT_WIDTH-1:0] o_overflow_cnt,
    output logic                 o_halt,
    output logic                 o_pass,
    output logic                 o_fail,
    output logic [31:0]          o_exit_code
);
    tracer_state_e        state_q, state_d;
    logic [CNT_WIDTH-1:0] retire_q, retire_d;
    logic [CNT_WIDTH-1:0] ovf_q, ovf_d;
    logic [31:0]          x10_q, x10_d, x17_q, x17_d;
    logic                 halt_q, halt_d, pass_q, pass_d, fail_q, fail_d;
    logic [31:0]          exit_q, exit_d;
    logic                 fifo_full_s, fifo_empty_s, capture_s, wr_eff_s, pop_s;
    trace_rec_t           rec_s, head_s;

    assign capture_s = i_ret_valid && (state_q == RUN);
    assign wr_eff_s  = i_ret_wr_rd && (i_ret_rd_addr != 5'd0);
    assign pop_s     = !fifo_empty_s && i_trace_ready;

    // Build the record; x0 writes are logged as no-write with zero data
    always_comb begin
        rec_s                    = '0;
        rec_s.pc                 = i_ret_pc;
        rec_s.flags[TRACE_WR_RD] = wr_eff_s;
        rec_s.flags[TRACE_TRAP]  = i_ret_trap;
        rec_s.flags[TRACE_MRET]  = i_ret_mret;
        if (wr_eff_s) begin
            rec_s.rd_addr = i_ret_rd_addr;
            rec_s.rd_data = i_ret_rd_data;
        end else begin
            rec_s.rd_addr = 5'd0;
            rec_s.rd_data = 32'd0;
        end
    end

    rv32i_trace_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (capture_s),
        .i_data  (rec_s),
        .i_pop   (pop_s),
        .o_data  (head_s),
        .o_full  (fifo_full_s),
        .o_empty (fifo_empty_s)
    );

    // Head record is zeroed while the FIFO is empty so stale storage never leaks
    always_comb begin
        o_trace_valid = !fifo_empty_s;
        if (!fifo_empty_s) begin
            o_trace_pc      = head_s.pc;
            o_trace_rd_addr = head_s.rd_addr;
            o_trace_rd_data = head_s.rd_data;
            o_trace_flags   = head_s.flags;
        end else begin
            o_trace_pc      = 32'd0;
            o_trace_rd_addr = 5'd0;
            o_trace_rd_data = 32'd0;
            o_trace_flags   = 3'd0;
        end
    end

    // Next-state: FSM, counters, shadows and the exit verdict
    always_comb begin
        state_d  = state_q;
        retire_d = retire_q;
        ovf_d    = ovf_q;
        x10_d    = x10_q;
        x17_d    = x17_q;
        halt_d   = halt_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        exit_d   = exit_q;
        case (state_q)
            RUN:     if (i_ecall || i_ebreak) state_d = DRAIN; else state_d = RUN;
            DRAIN:   if (fifo_empty_s) state_d = DONE; else state_d = DRAIN;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
        if (capture_s) begin
            retire_d = retire_q + CNT_WIDTH'(1);
            if (wr_eff_s && (i_ret_rd_addr == 5'd10)) x10_d = i_ret_rd_data;
            else x10_d = x10_q;
            if (wr_eff_s && (i_ret_rd_addr == 5'd17)) x17_d = i_ret_rd_data;
            else x17_d = x17_q;
        end else begin
            retire_d = retire_q;
        end
        if (capture_s && fifo_full_s && !pop_s && (ovf_q != {CNT_WIDTH{1'b1}})) begin
            ovf_d = ovf_q + CNT_WIDTH'(1);
        end else begin
            ovf_d = ovf_q;
        end
        if ((state_q == DRAIN) && (state_d == DONE)) begin
            halt_d = 1'b1;
            pass_d = (x17_q == EXIT_MAGIC) && (x10_q == 32'd0);
            fail_d = (x17_q == EXIT_MAGIC) && (x10_q != 32'd0);
            exit_d = x10_q >> 1;
        end else begin
            halt_d = halt_q;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= RUN;
            retire_q <= '0;
            ovf_q    <= '0;
            x10_q    <= 32'd0;
            x17_q    <= 32'd0;
            halt_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            exit_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            retire_q <= retire_d;
            ovf_q    <= ovf_d;
            x10_q    <= x10_d;
            x17_q    <= x17_d;
            halt_q   <= halt_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            exit_q   <= exit_d;
        end
    end

    assign o_retire_cnt   = retire_q;
    assign o_overflow_cnt = ovf_q;
    assign o_halt         = halt_q;
    assign o_pass         = pass_q;
    assign o_fail         = fail_q;
    assign o_exit_code    = exit_q;

endmodule

// File: tb/tb_rv32i_retire_tracer.sv
// Bench for rv32i_retire_tracer: directed and random retirements compared
// cycle by cycle against a queue-based reference model.
module tb_rv32i_retire_tracer;
    localparam int          DEPTH = 16;
    localparam logic [31:0] MAGIC = 32'h0000005d;

    logic        clk, rst_n;
    logic        ret_valid, ret_wr_rd, ret_trap, ret_mret, ecall, ebreak, trace_ready;
    logic [31:0] ret_pc, ret_rd_data;
    logic [4:0]  ret_rd_addr;
    logic        trace_valid, halt, pass, fail;
    logic [31:0] trace_pc, trace_rd_data, retire_cnt, overflow_cnt, exit_code;
    logic [4:0]  trace_rd_addr;
    logic [2:0]  trace_flags;

    rv32i_retire_tracer dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ret_valid(ret_valid), .i_ret_pc(ret_pc), .i_ret_wr_rd(ret_wr_rd),
        .i_ret_rd_addr(ret_rd_addr), .i_ret_rd_data(ret_rd_data),
        .i_ret_trap(ret_trap), .i_ret_mret(ret_mret),
        .i_ecall(ecall), .i_ebreak(ebreak),
        .o_trace_valid(trace_valid), .i_trace_ready(trace_ready),
        .o_trace_pc(trace_pc), .o_trace_rd_addr(trace_rd_addr),
        .o_trace_rd_data(trace_rd_data), .o_trace_flags(trace_flags),
        .o_retire_cnt(retire_cnt), .o_overflow_cnt(overflow_cnt),
        .o_halt(halt), .o_pass(pass), .o_fail(fail), .o_exit_code(exit_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  fl;
    } rec_t;

    rec_t        mq[$];
    int unsigned m_ret, m_ovf;
    bit          m_drain, m_done;
    logic [31:0] m_x10, m_x17;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        rec_t h;
        bit   v;
        v = (mq.size() > 0);
        h = '{32'd0, 5'd0, 32'd0, 3'd0};
        if (v) h = mq[0];
        chk({tag, ".valid"}, {31'd0, trace_valid}, {31'd0, v});
        chk({tag, ".pc"}, trace_pc, h.pc);
        chk({tag, ".rd"}, {27'd0, trace_rd_addr}, {27'd0, h.rd});
        chk({tag, ".data"}, trace_rd_data, h.data);
        chk({tag, ".flags"}, {29'd0, trace_flags}, {29'd0, h.fl});
        chk({tag, ".retire"}, retire_cnt, m_ret);
        chk({tag, ".ovf"}, overflow_cnt, m_ovf);
        chk({tag, ".halt"}, {31'd0, halt}, {31'd0, m_done});
        chk({tag, ".pass"}, {31'd0, pass}, {31'd0, m_done && m_x17 == MAGIC && m_x10 == 32'd0});
        chk({tag, ".fail"}, {31'd0, fail}, {31'd0, m_done && m_x17 == MAGIC && m_x10 != 32'd0});
        chk({tag, ".exit"}, exit_code, m_done ? (m_x10 >> 1) : 32'd0);
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(string tag, bit v, logic [31:0] pc, bit wr, logic [4:0] rd,
                        logic [31:0] data, bit trap, bit mret, bit ec, bit eb, bit rdy);
        int   pre;
        bit   pop, cap, run, go_drain, go_done, weff;
        rec_t r;
        ret_valid = v; ret_pc = pc; ret_wr_rd = wr; ret_rd_addr = rd; ret_rd_data = data;
        ret_trap = trap; ret_mret = mret; ecall = ec; ebreak = eb; trace_ready = rdy;
        pre      = mq.size();
        run      = !m_drain && !m_done;
        pop      = (pre > 0) && rdy;
        cap      = v && run;
        go_drain = run && (ec || eb);
        go_done  = m_drain && (pre == 0);
        if (pop) void'(mq.pop_front());
        if (cap) begin
            m_ret++;
            weff = wr && (rd != 5'd0);
            r.pc = pc;
            r.rd = weff ? rd : 5'd0;
            r.data = weff ? data : 32'd0;
            r.fl = {mret, trap, weff};
            if (pre < DEPTH || pop) mq.push_back(r);
            else if (m_ovf != 32'hffffffff) m_ovf++;
            if (weff && rd == 5'd10) m_x10 = data;
            if (weff && rd == 5'd17) m_x17 = data;
        end
        if (go_done) begin m_done = 1'b1; m_drain = 1'b0; end
        if (go_drain) m_drain = 1'b1;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(string tag, bit rdy, int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic ret(string tag, logic [31:0] pc, bit wr, logic [4:0] rd, logic [31:0] data, bit rdy);
        step(tag, 1'b1, pc, wr, rd, data, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset(int n);
        ret_valid = 1'b0; ret_pc = 32'd0; ret_wr_rd = 1'b0; ret_rd_addr = 5'd0;
        ret_rd_data = 32'd0; ret_trap = 1'b0; ret_mret = 1'b0; ecall = 1'b0;
        ebreak = 1'b0; trace_ready = 1'b0;
        rst_n = 1'b0;
        mq.delete();
        m_ret = 0; m_ovf = 0; m_drain = 1'b0; m_done = 1'b0; m_x10 = 32'd0; m_x17 = 32'd0;
        #1;
        chk("rst_async.valid", {31'd0, trace_valid}, 32'd0);
        chk("rst_async.retire", retire_cnt, 32'd0);
        chk("rst_async.halt", {31'd0, halt}, 32'd0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("post_rst");
    endtask

    initial begin
        logic [4:0] rd;
        rst_n = 1'b0;
        do_reset(2);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) ret("fill5", 32'h100 + 32'(i * 4), 1'b1, 5'd3, $urandom, 1'b0);
        do_reset(3);
        ret("after_rst", 32'h200, 1'b1, 5'd5, 32'hdead_beef, 1'b0);
        idle("after_rst_pop", 1'b1, 2);

        // Ordered drain
        do_reset(1);
        for (int i = 0; i < 4; i++) ret("ordered", 32'(i * 4), 1'b1, 5'd1 + 5'(i), $urandom, 1'b1);
        idle("ordered_tail", 1'b1, 2);

        // Backpressure overflow, then drain exactly 16
        do_reset(1);
        for (int i = 0; i < 20; i++) ret("ovf_fill", 32'h1000 + 32'(i * 4), 1'b1, 5'd2, $urandom, 1'b0);
        idle("ovf_drain", 1'b1, 18);

        // Full push+pop sustains occupancy without drops
        do_reset(1);
        for (int i = 0; i < 16; i++) ret("full_fill", 32'h2000 + 32'(i * 4), 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) ret("full_pp", 32'h3000 + 32'(i * 4), 1'b1, 5'd4, $urandom, 1'b1);
        idle("full_stall", 1'b0, 1);
        ret("full_drop", 32'h4000, 1'b0, 5'd0, 32'd0, 1'b0);

        // Random traffic
        do_reset(1);
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       rd = 5'd0;
                1:       rd = 5'd10;
                2:       rd = 5'd17;
                default: rd = 5'($urandom);
            endcase
            step("rand", $urandom_range(0, 3) != 0, $urandom, 1'($urandom), rd, $urandom,
                 1'($urandom), 1'($urandom), 1'b0, 1'b0, (i / 40) % 2 == 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0);
        end
        step("rand_ecall", 1'b1, 32'h5000, 1'b1, 5'd10, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle("rand_drain", 1'b1, 20);

        // Pass exit with three queued records
        do_reset(1);
        ret("pass_x17", 32'h0, 1'b1, 5'd17, MAGIC, 1'b0);
        ret("pass_x10", 32'h4, 1'b1, 5'd10, 32'd0, 1'b0);
        ret("pass_nop", 32'h8, 1'b0, 5'd0, 32'd0, 1'b0);
        step("pass_ecall", 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle("pass_drain", 1'b1, 6);
        ret("pass_sticky", 32'hc, 1'b1, 5'd10, 32'd9, 1'b1);
        chk("pass_flag", {31'd0, pass}, 32'd1);

        // Fail exit plus x0 write
        do_reset(1);
        ret("x0_write", 32'h10, 1'b1, 5'd0, 32'h55, 1'b0);
        ret("fail_x17", 32'h14, 1'b1, 5'd17, MAGIC, 1'b0);
        ret("fail_x10", 32'h18, 1'b1, 5'd10, 32'd7, 1'b0);
        step("fail_ebreak", 1'b1, 32'h1c, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle("fail_drain", 1'b1, 8);
        chk("fail_code", exit_code, 32'd3);

        // Exit with a non-magic x17 sets neither verdict
        do_reset(1);
        ret("nm_x17", 32'h20, 1'b1, 5'd17, 32'd1, 1'b1);
        ret("nm_x10", 32'h24, 1'b1, 5'd10, 32'd0, 1'b1);
        step("nm_ecall", 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle("nm_drain", 1'b1, 5);
        chk("nm_halt", {31'd0, halt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
